rsa_job_scheduler: RTL and testbench

Sequencer and two-way arbiter in front of a single `rsa_unit` instance (modular exponentiation C = P^E mod M with Montgomery constant Const). It accepts jobs from two requesters over four-phase req/done handshakes and grants them round-robin. For each granted job it latches the operands, clears and runs the unit, and captures the result on `eoc`. It sits between the host-side register interfaces and the RSA datapath.

---
 rtl/rsa_sched_pkg.sv | 21 ++
 rtl/rsa_rr_arbiter.sv | 22 ++
 rtl/rsa_job_scheduler.sv | 128 ++++++++++++
 tb/tb_rsa_job_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | rsa_sched_pkg: shared types and constants for the RSA job scheduler.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rsa_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NREQ            = 2;
  localparam int DEFAULT_TIMEOUT = 1023;

endpackage

`default_nettype wire

// File: rtl/rsa_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rsa_rr_arbiter: combinational two-way round-robin grant selection.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rsa_rr_arbiter
  import rsa_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last,
  output logic            gnt_idx,
  output logic            gnt_valid
);

  assign gnt_valid = |req;
  // On a tie the requester not served last wins; otherwise the single requester wins.
  assign gnt_idx   = (&req) ? ~last : req[1];

endmodule

`default_nettype wire

// File: rtl/rsa_job_scheduler.sv
// +----------------------------------------------------------------------------+
// | rsa_job_scheduler: two-requester job sequencer in front of one rsa_unit.   |
// | Optional RUN watchdog: define RSA_SCHED_TIMEOUT_EN.  Revision: 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module rsa_job_scheduler
  import rsa_sched_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*WIDTH-1:0] p_i,
  input  logic [NREQ*WIDTH-1:0] e_i,
  input  logic [NREQ*WIDTH-1:0] m_i,
  input  logic [NREQ*WIDTH-1:0] const_i,
  output logic [NREQ-1:0]      done_o,
  output logic                 err_o,
  output logic [WIDTH-1:0]     c_o,
  output logic                 busy_o,
  output logic                 rsa_rstb_o,
  output logic                 rsa_en_o,
  output logic [WIDTH-1:0]     rsa_p_o,
  output logic [WIDTH-1:0]     rsa_e_o,
  output logic [WIDTH-1:0]     rsa_m_o,
  output logic [WIDTH-1:0]     rsa_const_o,
  input  logic [WIDTH-1:0]     rsa_c_i,
  input  logic                 rsa_eoc_i
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("rsa_job_scheduler: TIMEOUT must be >= 1");
  end

  state_t state;
  logic   g;
  logic   last;
  logic   err_q;
  logic   gnt_idx;
  logic   gnt_valid;
  logic   timeout;

  rsa_rr_arbiter u_arb (
    .req       (req_i),
    .last      (last),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign rsa_rstb_o = rstb & (state != CLR);
  assign err_o      = err_q;

`ifdef RSA_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] run_cnt;

  // Counter holds at zero outside RUN, so it restarts on every RUN entry.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)               run_cnt <= '0;
    else if (state != RUN)   run_cnt <= '0;
    else if (!timeout)       run_cnt <= run_cnt + 1'b1;
  end

  assign timeout = (run_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      g           <= 1'b0;
      last        <= 1'b1;
      done_o      <= '0;
      err_q       <= 1'b0;
      c_o         <= '0;
      busy_o      <= 1'b0;
      rsa_en_o    <= 1'b0;
      rsa_p_o     <= '0;
      rsa_e_o     <= '0;
      rsa_m_o     <= '0;
      rsa_const_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            g           <= gnt_idx;
            rsa_p_o     <= p_i[int'(gnt_idx)*WIDTH +: WIDTH];
            rsa_e_o     <= e_i[int'(gnt_idx)*WIDTH +: WIDTH];
            rsa_m_o     <= m_i[int'(gnt_idx)*WIDTH +: WIDTH];
            rsa_const_o <= const_i[int'(gnt_idx)*WIDTH +: WIDTH];
            busy_o      <= 1'b1;
            state       <= CLR;
          end
        end
        CLR: begin
          rsa_en_o <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          // A result arriving in the timeout cycle takes priority over the abort.
          if (rsa_eoc_i || timeout) begin
            c_o       <= rsa_eoc_i ? rsa_c_i : '0;
            err_q     <= ~rsa_eoc_i;
            rsa_en_o  <= 1'b0;
            done_o[g] <= 1'b1;
            last      <= g;
            state     <= DONE;
          end
        end
        DONE: begin
          if (!req_i[g]) begin
            done_o <= '0;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rsa_job_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_rsa_job_scheduler: directed self-checking bench with a behavioural unit.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rsa_job_scheduler;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic [1:0]    req_i = '0;
  logic [2*W-1:0] p_i = '0, e_i = '0, m_i = '0, const_i = '0;
  logic [1:0]    done_o;
  logic          err_o, busy_o, rsa_rstb_o, rsa_en_o, rsa_eoc_i;
  logic [W-1:0]  c_o, rsa_p_o, rsa_e_o, rsa_m_o, rsa_const_o, rsa_c_i;

  int total = 0;
  int bad   = 0;
  int n;
  int eoc_lat   = 20;
  bit eoc_never = 1'b0;
  int mcnt      = 0;

  rsa_job_scheduler #(.WIDTH(W), .TIMEOUT(50)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .req_i       (req_i),
    .p_i         (p_i),
    .e_i         (e_i),
    .m_i         (m_i),
    .const_i     (const_i),
    .done_o      (done_o),
    .err_o       (err_o),
    .c_o         (c_o),
    .busy_o      (busy_o),
    .rsa_rstb_o  (rsa_rstb_o),
    .rsa_en_o    (rsa_en_o),
    .rsa_p_o     (rsa_p_o),
    .rsa_e_o     (rsa_e_o),
    .rsa_m_o     (rsa_m_o),
    .rsa_const_o (rsa_const_o),
    .rsa_c_i     (rsa_c_i),
    .rsa_eoc_i   (rsa_eoc_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] modexp(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m);
    logic [15:0] r, b;
    if (m == 8'd0) return 8'd0;
    r = 16'd1 % {8'd0, m};
    b = {8'd0, p} % {8'd0, m};
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = (r * b) % {8'd0, m};
      b = (b * b) % {8'd0, m};
    end
    return r[7:0];
  endfunction

  // Behavioural unit: eoc after eoc_lat enabled cycles, result from the latched operands.
  always @(posedge clk) begin
    if (!rsa_en_o) mcnt <= 0;
    else           mcnt <= mcnt + 1;
  end
  assign rsa_eoc_i = rsa_en_o && !eoc_never && (mcnt == eoc_lat);
  assign rsa_c_i   = modexp(rsa_p_o, rsa_e_o, rsa_m_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int limit, output int cycles);
    cycles = 0;
    while (done_o == 2'b00 && cycles < limit) begin
      tick();
      cycles++;
    end
    if (done_o == 2'b00) begin
      total++;
      bad++;
      $error("FAIL %s: observed=no done_o expected=done_o within %0d cycles", tag, limit);
    end
  endtask

  task automatic set_ops(input int r, input logic [7:0] p, input logic [7:0] e,
                         input logic [7:0] m, input logic [7:0] k);
    p_i[r*W +: W]     = p;
    e_i[r*W +: W]     = e;
    m_i[r*W +: W]     = m;
    const_i[r*W +: W] = k;
  endtask

  initial begin
    int g_exp;
    // Reset state
    tick();
    tick();
    check("rst_done",   32'(done_o), 32'd0);
    check("rst_busy",   32'(busy_o), 32'd0);
    check("rst_en",     32'(rsa_en_o), 32'd0);
    check("rst_rsarst", 32'(rsa_rstb_o), 32'd0);
    check("rst_c",      32'(c_o), 32'd0);
    check("rst_err",    32'(err_o), 32'd0);
    check("rst_p",      32'(rsa_p_o), 32'd0);
    rstb = 1'b1;
    #1;
    check("rel_rsarst", 32'(rsa_rstb_o), 32'd1);

    // Single job: 4^13 mod 197 = 26
    set_ops(0, 8'd4, 8'd13, 8'd197, 8'h5a);
    req_i = 2'b01;
    tick();
    check("s_clr_rsarst", 32'(rsa_rstb_o), 32'd0);
    check("s_clr_busy",   32'(busy_o), 32'd1);
    check("s_clr_en",     32'(rsa_en_o), 32'd0);
    check("s_p",          32'(rsa_p_o), 32'd4);
    check("s_e",          32'(rsa_e_o), 32'd13);
    check("s_m",          32'(rsa_m_o), 32'd197);
    check("s_const",      32'(rsa_const_o), 32'h5a);
    tick();
    check("s_run_rsarst", 32'(rsa_rstb_o), 32'd1);
    check("s_run_en",     32'(rsa_en_o), 32'd1);
    wait_done("s_done_wait", 100, n);
    check("s_latency", 32'(n), 32'd21);
    check("s_done",    32'(done_o), 32'b01);
    check("s_c",       32'(c_o), 32'd26);
    check("s_err",     32'(err_o), 32'd0);
    check("s_en_off",  32'(rsa_en_o), 32'd0);
    repeat (3) tick();
    check("s_hold", 32'(done_o), 32'b01);
    req_i = 2'b00;
    tick();
    check("s_rel_done", 32'(done_o), 32'b00);
    check("s_rel_busy", 32'(busy_o), 32'd0);

    // Tie from reset: 3^4 mod 10 = 1, 2^5 mod 13 = 6
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    tick();
    eoc_lat = 3;
    set_ops(0, 8'd3, 8'd4, 8'd10, 8'd1);
    set_ops(1, 8'd2, 8'd5, 8'd13, 8'd1);
    req_i = 2'b11;
    for (int j = 0; j < 4; j++) begin
      g_exp = j % 2;
      wait_done("tie_wait", 100, n);
      check("tie_done", 32'(done_o), 32'(1 << g_exp));
      check("tie_c",    32'(c_o), (g_exp == 1) ? 32'd6 : 32'd1);
      if (j == 3) req_i = 2'b00;
      else        req_i[g_exp] = 1'b0;
      tick();
      check("tie_rel", 32'(done_o), 32'b00);
      if (j < 3) req_i[g_exp] = 1'b1;
    end

    // Operand isolation: 7^5 mod 23 = 17
    set_ops(0, 8'd7, 8'd5, 8'd23, 8'd3);
    req_i = 2'b01;
    tick();
    tick();
    set_ops(0, 8'd9, 8'd9, 8'd23, 8'd3);
    tick();
    check("iso_p", 32'(rsa_p_o), 32'd7);
    check("iso_e", 32'(rsa_e_o), 32'd5);
    wait_done("iso_wait", 100, n);
    check("iso_done", 32'(done_o), 32'b01);
    check("iso_c",    32'(c_o), 32'd17);
    req_i = 2'b00;
    tick();

    // Early request drop on requester 1
    set_ops(1, 8'd2, 8'd5, 8'd13, 8'd1);
    req_i = 2'b10;
    tick();
    tick();
    req_i = 2'b00;
    wait_done("drop_wait", 100, n);
    check("drop_done", 32'(done_o), 32'b10);
    check("drop_c",    32'(c_o), 32'd6);
    tick();
    check("drop_pulse", 32'(done_o), 32'b00);
    check("drop_idle",  32'(busy_o), 32'd0);
    tick();
    check("drop_stay", 32'(busy_o), 32'd0);

    // Reset in the middle of RUN, then a fresh job
    eoc_lat = 20;
    set_ops(0, 8'd4, 8'd13, 8'd197, 8'd0);
    req_i = 2'b01;
    tick();
    tick();
    repeat (8) tick();
    rstb = 1'b0;
    #1;
    check("mr_done",   32'(done_o), 32'd0);
    check("mr_busy",   32'(busy_o), 32'd0);
    check("mr_en",     32'(rsa_en_o), 32'd0);
    check("mr_c",      32'(c_o), 32'd0);
    check("mr_err",    32'(err_o), 32'd0);
    check("mr_rsarst", 32'(rsa_rstb_o), 32'd0);
    check("mr_p",      32'(rsa_p_o), 32'd0);
    tick();
    rstb = 1'b1;
    tick();
    check("mr_clr",      32'(rsa_rstb_o), 32'd0);
    check("mr_clr_busy", 32'(busy_o), 32'd1);
    check("mr_clr_p",    32'(rsa_p_o), 32'd4);
    tick();
    check("mr_run_en", 32'(rsa_en_o), 32'd1);
    wait_done("mr_wait", 100, n);
    check("mr_latency", 32'(n), 32'd21);
    check("mr_done2",   32'(done_o), 32'b01);
    check("mr_c2",      32'(c_o), 32'd26);
    req_i = 2'b00;
    tick();

    // Unit never finishes
    eoc_never = 1'b1;
    set_ops(0, 8'd5, 8'd3, 8'd7, 8'd0);
    req_i = 2'b01;
    tick();
    tick();
`ifdef RSA_SCHED_TIMEOUT_EN
    wait_done("to_wait", 200, n);
    check("to_latency", 32'(n), 32'd50);
    check("to_done",    32'(done_o), 32'b01);
    check("to_err",     32'(err_o), 32'd1);
    check("to_c",       32'(c_o), 32'd0);
    req_i = 2'b00;
    tick();
    check("to_rel", 32'(done_o), 32'b00);
`else
    repeat (200) tick();
    check("hang_busy", 32'(busy_o), 32'd1);
    check("hang_done", 32'(done_o), 32'b00);
    check("hang_en",   32'(rsa_en_o), 32'd1);
    check("hang_err",  32'(err_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
